// File: rtl/complex_mult_s8.sv
// Two-stage pipelined signed complex multiplier: (a1 + j*b1) * (a2 + j*b2).
// Stage 1 registers the four full-precision products, stage 2 the combined, range-limited results.
module complex_mult_s8 #(
   parameter int DATA_W   = 8,
   parameter int OUT_W    = 8,
   parameter bit SATURATE = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] a1,
   input  logic signed [DATA_W-1:0] b1,
   input  logic signed [DATA_W-1:0] a2,
   input  logic signed [DATA_W-1:0] b2,
   output logic signed [OUT_W-1:0]  res_re,
   output logic signed [OUT_W-1:0]  res_im
);

   localparam int PW = 2 * DATA_W;
   localparam int SW = PW + 1;
   localparam logic signed [SW-1:0] MAX_V = SW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

   logic signed [PW-1:0] p_aa;
   logic signed [PW-1:0] p_bb;
   logic signed [PW-1:0] p_ab;
   logic signed [PW-1:0] p_ba;
   logic signed [SW-1:0] sum_re;
   logic signed [SW-1:0] sum_im;

   function automatic logic signed [OUT_W-1:0] fit(input logic signed [SW-1:0] v);
      if (SATURATE && (v > MAX_V))
         return MAX_V[OUT_W-1:0];
      else if (SATURATE && (v < MIN_V))
         return MIN_V[OUT_W-1:0];
      else
         return v[OUT_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_aa <= '0;
         p_bb <= '0;
         p_ab <= '0;
         p_ba <= '0;
      end else begin
         p_aa <= a1 * a2;
         p_bb <= b1 * b2;
         p_ab <= a1 * b2;
         p_ba <= b1 * a2;
      end
   end

   // One guard bit above the product width keeps the sum and difference exact.
   always_comb begin
      sum_re = {p_aa[PW-1], p_aa} - {p_bb[PW-1], p_bb};
      sum_im = {p_ab[PW-1], p_ab} + {p_ba[PW-1], p_ba};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_re <= '0;
         res_im <= '0;
      end else begin
         res_re <= fit(sum_re);
         res_im <= fit(sum_im);
      end
   end

endmodule

// File: tb/tb_complex_mult_s8.sv
// Scoreboard bench for complex_mult_s8: the driver queues expected results from a plain
// integer model, and an independent monitor compares them as the outputs appear.
module tb_complex_mult_s8;

   logic clk;
   logic rst_n;
   logic signed [7:0] a1;
   logic signed [7:0] b1;
   logic signed [7:0] a2;
   logic signed [7:0] b2;
   logic signed [7:0] res_re;
   logic signed [7:0] res_im;

   typedef struct {
      int                due;
      logic signed [7:0] re;
      logic signed [7:0] im;
   } exp_t;

   exp_t expQ[$];
   int   edgeCnt = 0;
   int   errors  = 0;
   int   checks  = 0;
   bit   done    = 0;

   complex_mult_s8 dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a1     (a1),
      .b1     (b1),
      .a2     (a2),
      .b2     (b2),
      .res_re (res_re),
      .res_im (res_im)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      edgeCnt = edgeCnt + 1;
   end

   function automatic logic signed [7:0] clampRef(input int v);
      int t;
      t = v;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      return t[7:0];
   endfunction

   // Drive one cycle of inputs before the next rising edge and queue what it must produce.
   task automatic applyStimulus(input bit rst, input int va1, input int vb1,
                                input int va2, input int vb2);
      exp_t e;
      int   nextEdge;
      @(negedge clk);
      rst_n = ~rst;
      a1 = va1[7:0];
      b1 = vb1[7:0];
      a2 = va2[7:0];
      b2 = vb2[7:0];
      nextEdge = edgeCnt + 1;
      if (rst) begin
         expQ.delete();
         e.due = nextEdge;     e.re = 8'sd0; e.im = 8'sd0; expQ.push_back(e);
         e.due = nextEdge + 1; e.re = 8'sd0; e.im = 8'sd0; expQ.push_back(e);
      end else begin
         e.due = nextEdge + 1;
         e.re  = clampRef(va1 * va2 - vb1 * vb2);
         e.im  = clampRef(va1 * vb2 + vb1 * va2);
         expQ.push_back(e);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      while (expQ.size() > 0 && expQ[0].due < edgeCnt) begin
         e = expQ.pop_front();
         checks = checks + 1;
         errors = errors + 1;
         $display("[TB] FAIL missed_result due edge %0d: got none, required re=%0d im=%0d",
                  e.due, e.re, e.im);
      end
      if (expQ.size() > 0 && expQ[0].due == edgeCnt) begin
         e = expQ.pop_front();
         checks = checks + 1;
         if (res_re !== e.re || res_im !== e.im) begin
            errors = errors + 1;
            $display("[TB] FAIL result edge %0d: got re=%0d im=%0d, required re=%0d im=%0d",
                     edgeCnt, res_re, res_im, e.re, e.im);
         end
      end
   endtask

   initial begin
      while (!done) begin
         @(posedge clk);
         #1;
         checkOutput();
      end
   end

   initial begin
      int r1, r2, r3, r4;
      rst_n = 1'b0;
      a1 = '0; b1 = '0; a2 = '0; b2 = '0;

      $display("[TB] reset");
      repeat (3) applyStimulus(1, 0, 0, 0, 0);

      $display("[TB] nominal");
      repeat (5) applyStimulus(0, -3, 9, 10, 9);

      $display("[TB] burst pattern");
      repeat (4) begin
         applyStimulus(0, 0, 0, 0, 0);
         applyStimulus(0, 0, 0, 0, 0);
         applyStimulus(0, -3, 9, 10, 9);
      end

      $display("[TB] saturation corners");
      repeat (3) applyStimulus(0, -128, -128, -128, -128);
      repeat (3) applyStimulus(0, -128, 0, 127, 0);
      applyStimulus(0, 127, -128, 127, 127);
      applyStimulus(0, -128, 127, -128, 127);

      $display("[TB] reset mid-stream");
      repeat (4) applyStimulus(0, -3, 9, 10, 9);
      applyStimulus(1, -3, 9, 10, 9);
      repeat (6) applyStimulus(0, -3, 9, 10, 9);

      $display("[TB] back-to-back");
      repeat (6) begin
         applyStimulus(0, -3, 9, 10, 9);
         applyStimulus(0, 1, 1, 1, 1);
      end

      $display("[TB] random");
      for (int i = 0; i < 400; i++) begin
         r1 = $signed(8'($urandom_range(0, 255)));
         r2 = $signed(8'($urandom_range(0, 255)));
         r3 = $signed(8'($urandom_range(0, 255)));
         r4 = $signed(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 7) == 0) r1 = -128;
         if ($urandom_range(0, 7) == 0) r4 = 127;
         applyStimulus($urandom_range(0, 39) == 0, r1, r2, r3, r4);
      end

      repeat (3) applyStimulus(0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      checks = checks + 1;
      if (expQ.size() != 0) begin
         errors = errors + 1;
         $display("[TB] FAIL drain: got %0d pending results, required 0", expQ.size());
      end
      done = 1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
